// File: rtl/dual_grant_arbiter_pkg.sv
// Shared constants, channel state type and helpers for the dual-grant arbiter.
// Requester count is fixed at 8 in this revision.
package dual_grant_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/dual_grant_arbiter_if.sv
// Request/release/grant bundle between the requesters and the arbiter.
// The master side drives req/done; the slave (arbiter) drives the grant view.
interface dual_grant_arbiter_if;
    import dual_grant_pkg::*;

    logic [N_REQ-1:0] req;
    logic [1:0]       done;
    logic [1:0]       gnt_vld;
    logic [IDX_W-1:0] gnt_idx0;
    logic [IDX_W-1:0] gnt_idx1;
    logic [N_REQ-1:0] gnt_vec;
    logic             err;

    modport master (
        output req, done,
        input  gnt_vld, gnt_idx0, gnt_idx1, gnt_vec, err
    );

    modport slave (
        input  req, done,
        output gnt_vld, gnt_idx0, gnt_idx1, gnt_vec, err
    );

endinterface

// File: rtl/dual_grant_arbiter_pick.sv
// Two-level priority find over a circular search order that descends from 'start'.
// With rotate=0 the order is always 7..0.
module dual_priority_pick
    import dual_grant_pkg::*;
(
    input  logic [N_REQ-1:0] elig,
    input  logic [IDX_W-1:0] start,
    input  logic             rotate,
    output logic [IDX_W-1:0] win1,
    output logic             win1_vld,
    output logic [IDX_W-1:0] win2,
    output logic             win2_vld
);

    logic [IDX_W-1:0] eff_start;
    logic [IDX_W-1:0] shift;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] rot2;
    logic [IDX_W-1:0] p1;
    logic [IDX_W-1:0] p2;

    // Rotate so that eff_start lands on bit 7; a plain highest-bit search then
    // walks the circular descending order, and adding 'shift' maps back.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        eff_start = rotate ? start : IDX_W'(N_REQ - 1);
        shift     = eff_start + IDX_W'(1);
        rot       = '0;
        p1        = '0;
        p2        = '0;
        win1_vld  = 1'b0;
        win2_vld  = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            rot[j] = elig[IDX_W'(j) + shift];
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (rot[j]) begin
                p1       = IDX_W'(j);
                win1_vld = 1'b1;
            end
        end
        rot2 = rot & ~onehot8(p1);
        for (int j = 0; j < N_REQ; j++) begin
            if (rot2[j]) begin
                p2       = IDX_W'(j);
                win2_vld = 1'b1;
            end
        end
        win1 = p1 + shift;
        win2 = p2 + shift;
    end

endmodule

// File: rtl/dual_grant_arbiter.sv
// Shares two service channels among 8 requesters; grants are registered and held
// until the owner pulses done. ROTATE selects fixed (7 high) or round-robin order.
module dual_grant_arbiter
    import dual_grant_pkg::*;
#(
    parameter int ROTATE = 0
) (
    input logic                clk,
    input logic                rst_n,
    dual_grant_arbiter_if.slave bus
);

    ch_state_t        ch_state [2];
    ch_state_t        ch_next  [2];
    logic [IDX_W-1:0] owner    [2];
    logic [IDX_W-1:0] gidx     [2];
    logic [IDX_W-1:0] last_ptr;
    logic             err_q;
    logic [1:0]       idle;
    logic [1:0]       grant;
    logic [N_REQ-1:0] vec;
    logic [IDX_W-1:0] win1, win2;
    logic             win1_vld, win2_vld;

    assign idle = {ch_state[1] == CH_IDLE, ch_state[0] == CH_IDLE};

    dual_priority_pick u_pick (
        .elig     (bus.req & ~vec),
        .start    (last_ptr - IDX_W'(1)),
        .rotate   (ROTATE != 0),
        .win1     (win1),
        .win1_vld (win1_vld),
        .win2     (win2),
        .win2_vld (win2_vld)
    );

    // Best winner goes to the lowest-numbered idle channel, runner-up to the other.
    always_comb begin
        grant   = 2'b00;
        gidx[0] = win1;
        gidx[1] = win1;
        case (idle)
            2'b11: begin
                grant   = {win2_vld, win1_vld};
                gidx[1] = win2;
            end
            2'b01:   grant = {1'b0, win1_vld};
            2'b10:   grant = {win1_vld, 1'b0};
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ch_next[c] = ch_state[c];
            case (ch_state[c])
                CH_IDLE: if (grant[c])    ch_next[c] = CH_BUSY;
                CH_BUSY: if (bus.done[c]) ch_next[c] = CH_IDLE;
                default: ch_next[c] = CH_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                ch_state[c] <= CH_IDLE;
                owner[c]    <= '0;
            end
            last_ptr <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                ch_state[c] <= ch_next[c];
                if (grant[c]) owner[c] <= gidx[c];
            end
            if (grant == 2'b11)  last_ptr <= win2;
            else if (|grant)     last_ptr <= win1;
            err_q <= err_q | (|(bus.done & idle));
        end
    end

    always_comb begin
        vec = '0;
        for (int c = 0; c < 2; c++) begin
            if (ch_state[c] == CH_BUSY) vec |= onehot8(owner[c]);
        end
    end

    assign bus.gnt_vld  = ~idle;
    assign bus.gnt_idx0 = owner[0];
    assign bus.gnt_idx1 = owner[1];
    assign bus.gnt_vec  = vec;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Bench for dual_grant_arbiter: one fixed-priority and one rotating instance,
// each compared every cycle against a list-based reference model.
module tb_dual_grant_arbiter;

    logic clk;
    logic rst_n;

    dual_grant_arbiter_if if_f ();
    dual_grant_arbiter_if if_r ();

    dual_grant_arbiter #(.ROTATE(0)) dut_f (.clk(clk), .rst_n(rst_n), .bus(if_f));
    dual_grant_arbiter #(.ROTATE(1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(if_r));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per instance m (0 fixed, 1 rotating), per channel c
    bit m_busy [2][2];
    int m_own  [2][2];
    int m_ptr  [2];
    bit m_err  [2];
    bit x_busy [2][2];
    int x_own  [2][2];
    int x_ptr  [2];
    bit x_err  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                m_busy[m][c] = 1'b0;
                m_own[m][c]  = 0;
            end
            m_ptr[m] = 0;
            m_err[m] = 1'b0;
        end
    endtask

    function automatic logic [7:0] model_vec(input int m);
        logic [7:0] v = '0;
        for (int c = 0; c < 2; c++) if (m_busy[m][c]) v[m_own[m][c]] = 1'b1;
        return v;
    endfunction

    // Next state from the rules: ordered eligible list, idle channels in ch0,ch1
    // order, the k-th idle channel takes the k-th list entry.
    task automatic model_eval(input int m, input logic [7:0] r, input logic [1:0] d);
        logic [7:0] elig;
        int         start;
        int         order[$];
        int         free[$];
        int         n;
        elig  = r & ~model_vec(m);
        start = (m == 1) ? (m_ptr[m] + 7) % 8 : 7;
        for (int k = 0; k < 8; k++) begin
            int idx = (start - k + 8) % 8;
            if (elig[idx]) order.push_back(idx);
        end
        for (int c = 0; c < 2; c++) begin
            x_busy[m][c] = m_busy[m][c];
            x_own[m][c]  = m_own[m][c];
            if (!m_busy[m][c]) free.push_back(c);
            else if (d[c]) x_busy[m][c] = 1'b0;
        end
        n = (free.size() < order.size()) ? free.size() : order.size();
        for (int i = 0; i < n; i++) begin
            x_busy[m][free[i]] = 1'b1;
            x_own[m][free[i]]  = order[i];
        end
        x_ptr[m] = (n > 0) ? order[n-1] : m_ptr[m];
        x_err[m] = m_err[m] | (d[0] & !m_busy[m][0]) | (d[1] & !m_busy[m][1]);
    endtask

    task automatic check_model(input int m);
        logic [1:0] vld;
        logic [2:0] i0, i1;
        logic [7:0] vec;
        logic       e;
        string      p;
        p = (m == 0) ? "fix" : "rot";
        if (m == 0) begin
            vld = if_f.gnt_vld; i0 = if_f.gnt_idx0; i1 = if_f.gnt_idx1; vec = if_f.gnt_vec; e = if_f.err;
        end else begin
            vld = if_r.gnt_vld; i0 = if_r.gnt_idx0; i1 = if_r.gnt_idx1; vec = if_r.gnt_vec; e = if_r.err;
        end
        check({p, ".gnt_vld"}, 32'(vld), 32'({m_busy[m][1], m_busy[m][0]}));
        check({p, ".gnt_vec"}, 32'(vec), 32'(model_vec(m)));
        check({p, ".err"}, 32'(e), 32'(m_err[m]));
        if (m_busy[m][0]) check({p, ".gnt_idx0"}, 32'(i0), 32'(m_own[m][0]));
        if (m_busy[m][1]) check({p, ".gnt_idx1"}, 32'(i1), 32'(m_own[m][1]));
    endtask

    task automatic tick();
        model_eval(0, if_f.req, if_f.done);
        model_eval(1, if_r.req, if_r.done);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                m_busy[m][c] = x_busy[m][c];
                m_own[m][c]  = x_own[m][c];
            end
            m_ptr[m] = x_ptr[m];
            m_err[m] = x_err[m];
        end
        check_model(0);
        check_model(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".f_vld"}, 32'(if_f.gnt_vld), 32'd0);
        check({tag, ".f_idx0"}, 32'(if_f.gnt_idx0), 32'd0);
        check({tag, ".f_idx1"}, 32'(if_f.gnt_idx1), 32'd0);
        check({tag, ".f_vec"}, 32'(if_f.gnt_vec), 32'd0);
        check({tag, ".f_err"}, 32'(if_f.err), 32'd0);
        check({tag, ".r_vld"}, 32'(if_r.gnt_vld), 32'd0);
        check({tag, ".r_vec"}, 32'(if_r.gnt_vec), 32'd0);
        check({tag, ".r_err"}, 32'(if_r.err), 32'd0);
    endtask

    initial begin
        int pair_hi[5] = '{7, 5, 3, 1, 7};
        rst_n     = 1'b0;
        if_f.req  = '0;
        if_f.done = '0;
        if_r.req  = '0;
        if_r.done = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check_all_zero("reset_release");

        // Fixed: both idle, two requesters
        if_f.req = 8'h82;
        tick();
        check("t1.vld", 32'(if_f.gnt_vld), 32'h3);
        check("t1.idx0", 32'(if_f.gnt_idx0), 32'd7);
        check("t1.idx1", 32'(if_f.gnt_idx1), 32'd1);
        check("t1.vec", 32'(if_f.gnt_vec), 32'h82);
        if_f.req = 8'h00;
        repeat (3) tick();
        check("t1.hold_vec", 32'(if_f.gnt_vec), 32'h82);
        if_f.done = 2'b11;
        tick();
        check("t1.release", 32'(if_f.gnt_vld), 32'h0);
        if_f.done = 2'b00;
        tick();

        // Fixed: ch0 holds 7, ch1 idle
        if_f.req = 8'h80;
        tick();
        if_f.req = 8'h24;
        tick();
        check("t2.ch1_idx", 32'(if_f.gnt_idx1), 32'd5);
        check("t2.vld", 32'(if_f.gnt_vld), 32'h3);
        if_f.done = 2'b01;
        tick();
        check("t2.ch0_released", 32'(if_f.gnt_vld), 32'h2);
        if_f.done = 2'b00;
        tick();
        check("t2.ch0_regrant", 32'(if_f.gnt_idx0), 32'd2);
        check("t2.vec", 32'(if_f.gnt_vec), 32'h24);
        if_f.req  = 8'h00;
        if_f.done = 2'b11;
        tick();
        if_f.done = 2'b00;
        tick();

        // Single requester: only ch0 granted; done on idle ch1 flags err
        if_f.req = 8'h01;
        repeat (4) begin
            tick();
            check("t3.vld", 32'(if_f.gnt_vld), 32'h1);
            check("t3.idx0", 32'(if_f.gnt_idx0), 32'd0);
        end
        if_f.done = 2'b10;
        tick();
        check("t4.err_set", 32'(if_f.err), 32'd1);
        check("t4.vld_kept", 32'(if_f.gnt_vld), 32'h1);
        if_f.done = 2'b00;
        repeat (2) tick();
        check("t4.err_sticky", 32'(if_f.err), 32'd1);
        if_f.req  = 8'h00;
        if_f.done = 2'b01;
        tick();
        if_f.done = 2'b00;
        tick();

        // Rotating: all requesting, both released each round
        if_r.req = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rot.vld", 32'(if_r.gnt_vld), 32'h3);
            check("rot.idx0", 32'(if_r.gnt_idx0), 32'(pair_hi[k]));
            check("rot.idx1", 32'(if_r.gnt_idx1), 32'(pair_hi[k] - 1));
            if_r.done = 2'b11;
            tick();
            check("rot.released", 32'(if_r.gnt_vld), 32'h0);
            if_r.done = 2'b00;
        end
        if_r.req = 8'h00;
        tick();

        // Random traffic on both instances
        for (int t = 0; t < 600; t++) begin
            logic [7:0] r;
            logic [1:0] d;
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            if_f.req = r;
            d = 2'($urandom) & {m_busy[0][1], m_busy[0][0]};
            if ($urandom_range(0, 49) == 0) d = 2'($urandom);
            if_f.done = d;
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            if_r.req = r;
            d = 2'($urandom) & {m_busy[1][1], m_busy[1][0]};
            if ($urandom_range(0, 49) == 0) d = 2'($urandom);
            if_r.done = d;
            tick();
        end

        // Asynchronous reset while grants are held
        if_f.req  = 8'hFF;
        if_f.done = 2'b00;
        if_r.req  = 8'hFF;
        if_r.done = 2'b00;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("post_reset");
        if_f.req = 8'h00;
        if_r.req = 8'h00;
        tick();
        if_r.req = 8'hFF;
        tick();
        check("rot.after_reset_idx0", 32'(if_r.gnt_idx0), 32'd7);
        check("rot.after_reset_idx1", 32'(if_r.gnt_idx1), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
